// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encoding, defaults and
// watchdog sizing helper.
package mul_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_RSP  = 2'd3;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 40;

  // Watchdog must hold values up to TIMEOUT.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// searching upward and wrapping at NUM_REQ.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Modulo by conditional subtract keeps non-power-of-two NUM_REQ correct.
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one sequential multiplier among NUM_REQ requesters: round-robin grant,
// load/run sequencing, watchdog abort and a held, id-tagged response.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic                        mul_load,
  output logic                        mul_run,
  output logic [WIDTH-1:0]            mul_a,
  output logic [WIDTH-1:0]            mul_b,
  input  logic                        mul_ready,
  input  logic [2*WIDTH-1:0]          mul_product,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [2*WIDTH-1:0]          rsp_product,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = wd_width(TIMEOUT);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  logic [WD_W-1:0]    wd;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // Grant is combinational so it lands in the IDLE cycle; masked during reset
  // so every output reads zero while Reset is high.
  assign req_grant = (state == S_IDLE && !Reset) ? gnt : '0;
  assign mul_load  = (state == S_LOAD);
  assign mul_run   = (state == S_RUN);
  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wd          <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_gnt) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            rsp_id <= gnt_idx;
            ptr    <= ptr_nxt;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          wd    <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // A ready multiplier wins over a watchdog expiring in the same cycle.
          if (mul_ready) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            state       <= S_RSP;
          end else if (wd == WD_W'(TIMEOUT-1)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            err_timeout <= 1'b1;
            state       <= S_RSP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: multiplier stub, transaction-level
// reference model with per-cycle compare, and directed scenarios.
module tb_mul_scheduler;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int TO = 40;

  logic            clk;
  logic            Reset;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_grant;
  logic            mul_load;
  logic            mul_run;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_ready;
  logic [2*W-1:0]  mul_product;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_product;
  logic            rsp_err;
  logic            busy;
  logic            err_timeout;

  int checks   = 0;
  int failures = 0;

  mul_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_grant   (req_grant),
    .mul_load    (mul_load),
    .mul_run     (mul_run),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_ready   (mul_ready),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: ready becomes visible in RUN cycle stub_lat+1.
  int          stub_lat;
  logic        stub_hang;
  logic [W-1:0] s_a, s_b;
  int          s_cnt;
  logic        s_rdy;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s_a <= '0; s_b <= '0; s_cnt <= 0; s_rdy <= 1'b0;
    end else if (mul_load) begin
      s_a <= mul_a; s_b <= mul_b; s_cnt <= stub_lat; s_rdy <= 1'b0;
    end else if (mul_run && !s_rdy) begin
      if (s_cnt != 0) s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_rdy <= 1'b1;
    end
  end

  assign mul_ready   = s_rdy && !stub_hang;
  assign mul_product = s_rdy ? ({32'h0, s_a} * {32'h0, s_b}) : 64'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: phases are idle / load / run / respond, with run length
  // derived from the stub latency and the timeout rule.
  int            m_phase, m_p, m_left, m_runlen, m_id, w, j;
  logic          found, m_err, m_sticky;
  logic [W-1:0]  m_a, m_b;
  logic [63:0]   m_prod;
  logic [NR-1:0] exp_g;

  initial begin
    m_phase = 0; m_p = 0; m_sticky = 1'b0; m_prod = '0;
  end

  always @(negedge clk) begin
    if (Reset) begin
      m_phase  = 0;
      m_p      = 0;
      m_sticky = 1'b0;
    end else begin
      chk("err_timeout", {63'h0, err_timeout}, {63'h0, m_sticky});
      case (m_phase)
        0: begin
          found = 1'b0; w = 0; exp_g = '0;
          for (int k = 0; k < NR; k++) begin
            j = (m_p + k) % NR;
            if (!found && req_valid[j]) begin found = 1'b1; w = j; end
          end
          if (found) exp_g[w] = 1'b1;
          chk("idle_grant", {60'h0, req_grant}, {60'h0, exp_g});
          chk("idle_busy", {63'h0, busy}, 64'h0);
          chk("idle_load", {63'h0, mul_load}, 64'h0);
          chk("idle_run", {63'h0, mul_run}, 64'h0);
          chk("idle_rsp_valid", {63'h0, rsp_valid}, 64'h0);
          if (found) begin
            m_id     = w;
            m_a      = req_a[w*W +: W];
            m_b      = req_b[w*W +: W];
            m_err    = stub_hang || (stub_lat >= TO);
            m_prod   = m_err ? 64'h0 : ({32'h0, m_a} * {32'h0, m_b});
            m_runlen = m_err ? TO : stub_lat + 1;
            m_p      = (w + 1) % NR;
            m_phase  = 1;
          end
        end
        1: begin
          chk("load_pulse", {63'h0, mul_load}, 64'h1);
          chk("load_run", {63'h0, mul_run}, 64'h0);
          chk("load_busy", {63'h0, busy}, 64'h1);
          chk("load_grant", {60'h0, req_grant}, 64'h0);
          chk("load_mul_a", {32'h0, mul_a}, {32'h0, m_a});
          chk("load_mul_b", {32'h0, mul_b}, {32'h0, m_b});
          m_left  = m_runlen;
          m_phase = 2;
        end
        2: begin
          chk("run_level", {63'h0, mul_run}, 64'h1);
          chk("run_load", {63'h0, mul_load}, 64'h0);
          chk("run_grant", {60'h0, req_grant}, 64'h0);
          chk("run_rsp_valid", {63'h0, rsp_valid}, 64'h0);
          chk("run_mul_a", {32'h0, mul_a}, {32'h0, m_a});
          chk("run_mul_b", {32'h0, mul_b}, {32'h0, m_b});
          m_left--;
          if (m_left == 0) begin
            m_sticky = m_sticky | m_err;
            m_phase  = 3;
          end
        end
        default: begin
          chk("rsp_valid", {63'h0, rsp_valid}, 64'h1);
          chk("rsp_id", {62'h0, rsp_id}, 64'(m_id));
          chk("rsp_product", rsp_product, m_prod);
          chk("rsp_err", {63'h0, rsp_err}, {63'h0, m_err});
          chk("rsp_grant", {60'h0, req_grant}, 64'h0);
          chk("rsp_run", {63'h0, mul_run}, 64'h0);
          if (rsp_ready) m_phase = 0;
        end
      endcase
    end
  end

  task automatic issue_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic drop(input int i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_grant(output int g, output time t);
    g = -1; t = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_grant != '0) begin
        for (int i = 0; i < NR; i++) if (req_grant[i]) g = i;
        t = $time;
        break;
      end
    end
    if (g < 0) fail_to("wait_grant");
  endtask

  task automatic wait_rsp(output time t);
    t = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid) begin t = $time; break; end
    end
    if (t == 0) fail_to("wait_rsp");
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_to("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  int  g;
  time tg, tr;
  int  glog [5];
  int  exp_order [5];
  logic [63:0] held_prod;

  initial begin
    Reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; stub_hang = 1'b0; stub_lat = 32;
    exp_order = '{0, 1, 2, 3, 0};
    #2;
    chk("reset_grant", {60'h0, req_grant}, 64'h0);
    chk("reset_load", {63'h0, mul_load}, 64'h0);
    chk("reset_run", {63'h0, mul_run}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("reset_product", rsp_product, 64'h0);
    chk("reset_err_timeout", {63'h0, err_timeout}, 64'h0);
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;

    // Single request, 7 x 6.
    issue_req(0, 32'd7, 32'd6);
    wait_grant(g, tg);
    chk("t1_grant_idx", 64'(g), 64'd0);
    drop(0);
    @(negedge clk);
    chk("t1_load_next_cycle", {63'h0, mul_load}, 64'h1);
    wait_rsp(tr);
    chk("t1_latency", 64'((tr - tg) / 10), 64'd35);
    chk("t1_product", rsp_product, 64'd42);
    chk("t1_id", {62'h0, rsp_id}, 64'd0);
    chk("t1_err", {63'h0, rsp_err}, 64'd0);
    chk("t1_model_product", m_prod, 64'd42);
    wait_idle();

    // All-ones operands from requester 3; leaves the pointer at 0.
    issue_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_grant(g, tg);
    chk("t3_grant_idx", 64'(g), 64'd3);
    drop(3);
    wait_rsp(tr);
    chk("t3_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
    wait_idle();

    // All four requesting continuously.
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = 32'(i + 2);
      req_b[i*W +: W] = 32'(100 + i);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, tg);
      glog[k] = g;
      @(posedge clk); #1;
      if (g >= 0) req_a[g*W +: W] = req_a[g*W +: W] + 32'd5;
      if (k == 4) req_valid = '0;
    end
    for (int k = 0; k < 5; k++) chk("t2_grant_order", 64'(glog[k]), 64'(exp_order[k]));
    wait_idle();

    // Backpressure with a competing request pending.
    rsp_ready = 1'b0;
    issue_req(2, 32'd12345, 32'd678);
    wait_grant(g, tg);
    chk("t4_grant_idx", 64'(g), 64'd2);
    drop(2);
    wait_rsp(tr);
    issue_req(3, 32'd3, 32'd5);
    held_prod = 64'd8369910;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", {63'h0, rsp_valid}, 64'h1);
      chk("t4_hold_product", rsp_product, held_prod);
      chk("t4_hold_id", {62'h0, rsp_id}, 64'd2);
      chk("t4_no_grant", {60'h0, req_grant}, 64'h0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_busy", {63'h0, busy}, 64'h0);
    chk("t4_idle_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("t4_next_grant", {60'h0, req_grant}, 64'h8);
    drop(3);
    wait_idle();

    // Hung multiplier: abort after TIMEOUT run cycles.
    stub_hang = 1'b1;
    issue_req(1, 32'd9, 32'd9);
    wait_grant(g, tg);
    drop(1);
    wait_rsp(tr);
    chk("t5_latency", 64'((tr - tg) / 10), 64'd42);
    chk("t5_err", {63'h0, rsp_err}, 64'h1);
    chk("t5_product", rsp_product, 64'h0);
    chk("t5_err_timeout", {63'h0, err_timeout}, 64'h1);
    wait_idle();
    stub_hang = 1'b0;

    // Ready on the final allowed run cycle wins over the watchdog.
    stub_lat = 39;
    issue_req(0, 32'd2, 32'd3);
    wait_grant(g, tg);
    drop(0);
    wait_rsp(tr);
    chk("tb_edge_ok_err", {63'h0, rsp_err}, 64'h0);
    chk("tb_edge_ok_product", rsp_product, 64'd6);
    wait_idle();

    // One cycle too slow: abort.
    stub_lat = 40;
    issue_req(0, 32'd4, 32'd5);
    wait_grant(g, tg);
    drop(0);
    wait_rsp(tr);
    chk("tb_edge_late_err", {63'h0, rsp_err}, 64'h1);
    chk("tb_edge_late_product", rsp_product, 64'h0);
    wait_idle();
    chk("t5_sticky", {63'h0, err_timeout}, 64'h1);

    // Reset mid-RUN with pointer at 2, then arbitration restarts from 0.
    stub_lat = 32;
    issue_req(1, 32'd11, 32'd13);
    wait_grant(g, tg);
    drop(1);
    repeat (5) @(negedge clk);
    chk("t6_in_run", {63'h0, mul_run}, 64'h1);
    #3 Reset = 1'b1;
    req_a[0 +: W] = 32'd1; req_b[0 +: W] = 32'd1;
    req_a[3*W +: W] = 32'd2; req_b[3*W +: W] = 32'd2;
    req_valid = 4'b1001;
    #1;
    chk("t6_grant", {60'h0, req_grant}, 64'h0);
    chk("t6_run", {63'h0, mul_run}, 64'h0);
    chk("t6_busy", {63'h0, busy}, 64'h0);
    chk("t6_mul_a", {32'h0, mul_a}, 64'h0);
    chk("t6_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("t6_rsp_id", {62'h0, rsp_id}, 64'h0);
    chk("t6_err_timeout", {63'h0, err_timeout}, 64'h0);
    @(posedge clk); @(posedge clk); #1 Reset = 1'b0;
    wait_grant(g, tg);
    chk("t6_first_grant", 64'(g), 64'd0);
    drop(0);
    wait_grant(g, tg);
    chk("t6_second_grant", 64'(g), 64'd3);
    drop(3);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
